serial_parity_deserializer: RTL and testbench



---
 rtl/serial_parity_pkg.sv | 16 +
 rtl/serial_parity_deserializer.sv | 116 +++++++++++
 tb/tb_serial_parity_deserializer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_pkg.sv
// Shared types and sizing helpers for the serial parity deserializer.
package serial_parity_pkg;

  // Frame phases: collecting data bits, awaiting parity bit, holding result.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Bit counter width for a WIDTH-bit frame (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_parity_deserializer.sv
// Serial-to-parallel deserializer with running parity check.
// Frame: WIDTH data bits LSB first, then one parity bit.
module serial_parity_deserializer
  import serial_parity_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             parity_ok
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q,     state_d;
  logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic             acc_q,       acc_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             parity_ok_q, parity_ok_d;

  logic accept;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign parity_ok = parity_ok_q;

  // Next-state and datapath update for the frame FSM.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    parity_ok_d = parity_ok_q;

    case (state_q)
      COLLECT: begin
        if (sync_clr) begin
          bit_cnt_d = '0;
          acc_d     = 1'b0;
          shift_d   = '0;
        end else if (accept) begin
          shift_d[bit_cnt_q] = in_bit;
          acc_d              = acc_q ^ in_bit;
          bit_cnt_d          = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        if (sync_clr) begin
          state_d   = COLLECT;
          bit_cnt_d = '0;
          acc_d     = 1'b0;
          shift_d   = '0;
        end else if (accept) begin
          out_data_d  = shift_q;
          parity_ok_d = ((acc_q ^ in_bit) == ODD_PARITY);
          out_valid_d = 1'b1;
          bit_cnt_d   = '0;
          acc_d       = 1'b0;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        // sync_clr is ignored here so a completed word is never dropped.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      bit_cnt_q   <= '0;
      acc_q       <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      parity_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      parity_ok_q <= parity_ok_d;
    end
  end

endmodule

// File: tb/tb_serial_parity_deserializer.sv
// Self-checking bench: even- and odd-parity instances share one stimulus stream.
module tb_serial_parity_deserializer;

  logic       clk;
  logic       rst_n;
  logic       sync_clr;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;

  logic       in_ready_e,  in_ready_o;
  logic       out_valid_e, out_valid_o;
  logic [7:0] out_data_e,  out_data_o;
  logic       parity_ok_e, parity_ok_o;

  int checks   = 0;
  int failures = 0;

  serial_parity_deserializer #(.WIDTH(8), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(in_ready_e), .in_bit(in_bit),
    .out_valid(out_valid_e), .out_ready(out_ready),
    .out_data(out_data_e), .parity_ok(parity_ok_e)
  );

  serial_parity_deserializer #(.WIDTH(8), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(in_ready_o), .in_bit(in_bit),
    .out_valid(out_valid_o), .out_ready(out_ready),
    .out_data(out_data_o), .parity_ok(parity_ok_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: collect accepted bits in a queue; a full frame of
  // nine bits yields the word and the XOR of everything received.
  logic       bits[$];
  logic       m_hold;
  logic [7:0] m_data;
  logic       m_ok_e, m_ok_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits.delete();
      m_hold = 1'b0;
      m_data = 8'h00;
      m_ok_e = 1'b0;
      m_ok_o = 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (sync_clr) begin
      bits.delete();
    end else if (in_valid) begin
      bits.push_back(in_bit);
      if (bits.size() == 9) begin
        logic [7:0] w;
        logic       x;
        w = 8'h00;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
          w[i] = bits[i];
          x    = x ^ bits[i];
        end
        x      = x ^ bits[8];
        m_data = w;
        m_ok_e = (x == 1'b0);
        m_ok_o = (x == 1'b1);
        m_hold = 1'b1;
        bits.delete();
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_in_ready_e",  32'(in_ready_e),  32'(!m_hold));
    chk("cmp_in_ready_o",  32'(in_ready_o),  32'(!m_hold));
    chk("cmp_out_valid_e", 32'(out_valid_e), 32'(m_hold));
    chk("cmp_out_valid_o", 32'(out_valid_o), 32'(m_hold));
    chk("cmp_out_data_e",  32'(out_data_e),  32'(m_data));
    chk("cmp_out_data_o",  32'(out_data_o),  32'(m_data));
    chk("cmp_parity_ok_e", 32'(parity_ok_e), 32'(m_ok_e));
    chk("cmp_parity_ok_o", 32'(parity_ok_o), 32'(m_ok_o));
  end

  // Offer one bit for exactly one cycle; the block must be ready.
  task automatic beat(input logic b);
    chk("beat_in_ready", 32'(in_ready_e), 32'd1);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Send n data bits LSB first with random idle gaps up to maxgap.
  task automatic send_bits(input logic [7:0] d, input int unsigned n, input int unsigned maxgap);
    for (int unsigned i = 0; i < n; i++) begin
      idle($urandom_range(0, maxgap));
      beat(d[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int unsigned maxgap);
    send_bits(d, 8, maxgap);
    idle($urandom_range(0, maxgap));
    beat(p);
  endtask

  // Literal expectations, sampled one cycle after the parity beat.
  task automatic expect_out(input string name, input logic [7:0] d, input logic ok_e, input logic ok_o);
    chk({name, "_valid"}, 32'(out_valid_e & out_valid_o), 32'd1);
    chk({name, "_data"},  32'(out_data_e), 32'(d));
    chk({name, "_ok_e"},  32'(parity_ok_e), 32'(ok_e));
    chk({name, "_ok_o"},  32'(parity_ok_o), 32'(ok_o));
  endtask

  initial begin
    rst_n     = 1'b1;
    sync_clr  = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    idle(2);
    chk("reset_valid", 32'(out_valid_e | out_valid_o), 32'd0);
    chk("reset_data",  32'(out_data_e | out_data_o), 32'd0);
    chk("reset_ok",    32'(parity_ok_e | parity_ok_o), 32'd0);
    chk("reset_ready", 32'(in_ready_e & in_ready_o), 32'd1);
    rst_n = 1'b1;
    idle(1);

    // Basic frames; out_valid must be up right after the parity beat.
    send_frame(8'hA5, 1'b0, 0);
    expect_out("a5_p0", 8'hA5, 1'b1, 1'b0);
    idle(1);
    chk("a5_p0_drop", 32'(out_valid_e), 32'd0);
    send_frame(8'hA5, 1'b1, 0);
    expect_out("a5_p1", 8'hA5, 1'b0, 1'b1);
    idle(1);
    send_frame(8'hFF, 1'b0, 0);
    expect_out("ff_p0", 8'hFF, 1'b1, 1'b0);
    idle(1);

    // Backpressure: bits offered during HOLD must not be consumed.
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      expect_out("bp_hold", 8'h3C, 1'b1, 1'b0);
      chk("bp_in_ready", 32'(in_ready_e), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    send_frame(8'hA5, 1'b0, 0);
    expect_out("after_bp", 8'hA5, 1'b1, 1'b0);
    idle(1);

    // Gapped frame.
    send_frame(8'h81, 1'b0, 5);
    expect_out("gap_81", 8'h81, 1'b1, 1'b0);
    idle(1);

    // Asynchronous reset mid-frame, asserted between clock edges.
    send_bits(8'hFF, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(out_valid_e | out_valid_o), 32'd0);
    chk("areset_data",  32'(out_data_e | out_data_o), 32'd0);
    chk("areset_ok",    32'(parity_ok_e | parity_ok_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h5A, 1'b0, 0);
    expect_out("post_rst_5a", 8'h5A, 1'b1, 1'b0);
    idle(1);

    // sync_clr after five bits, with a bit offered in the same cycle.
    send_bits(8'hFF, 5, 0);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk); #1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    send_frame(8'h5A, 1'b0, 1);
    expect_out("post_clr_5a", 8'h5A, 1'b1, 1'b0);
    idle(1);

    // sync_clr coinciding with the parity beat wins: no output.
    send_bits(8'h0F, 8, 0);
    sync_clr = 1'b1;
    beat(1'b0);
    sync_clr = 1'b0;
    chk("clr_parity_noout", 32'(out_valid_e | out_valid_o), 32'd0);
    idle(1);
    chk("clr_parity_noout2", 32'(out_valid_e), 32'd0);
    send_frame(8'h5A, 1'b0, 0);
    expect_out("post_clrp_5a", 8'h5A, 1'b1, 1'b0);
    idle(1);

    // Odd parity frames; sync_clr during HOLD keeps the word.
    send_frame(8'h01, 1'b1, 0);
    expect_out("01_p1", 8'h01, 1'b1, 1'b0);
    idle(1);
    out_ready = 1'b0;
    send_frame(8'h01, 1'b0, 0);
    sync_clr = 1'b1;
    idle(2);
    expect_out("hold_clr", 8'h01, 1'b0, 1'b1);
    sync_clr  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("hold_clr_drop", 32'(out_valid_o), 32'd0);
    chk("hold_keep_data", 32'(out_data_o), 32'h01);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
